// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for the pipelined ALU.
// Latency: none, wiring only.
// Backpressure: in_valid/in_ready on the request side, out_valid/out_ready on the result side.
interface alu_pipe_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   opcode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             a_is_zero;
    logic             zero;
    logic             carry;
    logic             illegal;

    // Producer of operations and consumer of results.
    modport master (
        output in_valid, in_a, in_b, opcode, out_ready,
        input  in_ready, out_valid, alu_out, a_is_zero, zero, carry, illegal
    );

    // The ALU itself.
    modport slave (
        input  in_valid, in_a, in_b, opcode, out_ready,
        output in_ready, out_valid, alu_out, a_is_zero, zero, carry, illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Registered ALU with legacy opcodes 0-7, SUB/OR/shifts and a serial shift-add MUL.
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for MUL when the output is free.
// Backpressure: in_ready drops while MUL runs or while a held result is not consumed.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int OPW   = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_pipe_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [OPW-1:0] OP_ADD = OPW'(2);
    localparam logic [OPW-1:0] OP_AND = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_LDA = OPW'(5);
    localparam logic [OPW-1:0] OP_SUB = OPW'(8);
    localparam logic [OPW-1:0] OP_OR  = OPW'(9);
    localparam logic [OPW-1:0] OP_SHL = OPW'(10);
    localparam logic [OPW-1:0] OP_SHR = OPW'(11);
    localparam logic [OPW-1:0] OP_MUL = OPW'(12);
    localparam logic [OPW-1:0] OP_I13 = OPW'(13);
    localparam logic [OPW-1:0] OP_I14 = OPW'(14);
    localparam logic [OPW-1:0] OP_I15 = OPW'(15);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mul_az_q, mul_az_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   alu_out_q, alu_out_d;
    logic               az_q, az_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               illegal_q, illegal_d;

    logic               out_free, in_ready, in_fire;
    logic [WIDTH:0]     sum, diff;
    logic [WIDTH-1:0]   op_res;
    logic               op_c, op_il;
    logic               wr;
    logic [WIDTH-1:0]   wr_res;
    logic               wr_c, wr_az, wr_il;

    // The output slot is free when empty or being drained this edge.
    assign out_free = !out_valid_q || bus.out_ready;
    assign in_ready = (state_q == S_IDLE) && out_free;
    assign in_fire  = bus.in_valid && in_ready;
    assign sum      = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    assign diff     = {1'b0, bus.in_a} - {1'b0, bus.in_b};

    // Single-cycle result and carry for the presented opcode.
    always_comb begin
        op_res = bus.in_a;
        op_c   = 1'b0;
        op_il  = 1'b0;
        case (bus.opcode)
            OP_ADD: begin op_res = sum[WIDTH-1:0];  op_c = sum[WIDTH];  end
            OP_AND: op_res = bus.in_a & bus.in_b;
            OP_XOR: op_res = bus.in_a ^ bus.in_b;
            OP_LDA: op_res = bus.in_b;
            OP_SUB: begin op_res = diff[WIDTH-1:0]; op_c = diff[WIDTH]; end
            OP_OR:  op_res = bus.in_a | bus.in_b;
            OP_SHL: begin op_res = bus.in_a << 1;   op_c = bus.in_a[WIDTH-1]; end
            OP_SHR: begin op_res = bus.in_a >> 1;   op_c = bus.in_a[0];       end
            OP_I13, OP_I14, OP_I15: op_il = 1'b1;
            default: op_res = bus.in_a;
        endcase
    end

    // Sequencer: accept, run the serial multiplier, and load the result registers.
    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        mul_az_d    = mul_az_q;
        out_valid_d = bus.out_ready ? 1'b0 : out_valid_q;
        alu_out_d   = alu_out_q;
        az_d        = az_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        illegal_d   = illegal_q;
        wr          = 1'b0;
        wr_res      = op_res;
        wr_c        = op_c;
        wr_az       = (bus.in_a == '0);
        wr_il       = op_il;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    if (bus.opcode == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, bus.in_a};
                        mplier_d = bus.in_b;
                        prod_d   = '0;
                        cnt_d    = CW'(WIDTH);
                        mul_az_d = (bus.in_a == '0);
                        state_d  = S_MUL;
                    end else begin
                        wr = 1'b1;
                    end
                end
            end
            S_MUL: begin
                if (mplier_q[0]) prod_d = prod_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_free) begin
                    wr      = 1'b1;
                    wr_res  = prod_q[WIDTH-1:0];
                    wr_c    = |prod_q[2*WIDTH-1:WIDTH];
                    wr_az   = mul_az_q;
                    wr_il   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new result wins over the drain of the previous one.
        if (wr) begin
            out_valid_d = 1'b1;
            alu_out_d   = wr_res;
            zero_d      = (wr_res == '0);
            carry_d     = wr_c;
            az_d        = wr_az;
            illegal_d   = wr_il;
        end
    end

    // State and result registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            mul_az_q    <= 1'b0;
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            az_q        <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            mul_az_q    <= mul_az_d;
            out_valid_q <= out_valid_d;
            alu_out_q   <= alu_out_d;
            az_q        <= az_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_out   = alu_out_q;
    assign bus.a_is_zero = az_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at WIDTH=4: opcode table, MUL, backpressure, reset.
// Latency: checks single-cycle results one edge after accept, MUL at WIDTH+1 edges.
// Backpressure: exercises out_ready=0 holds and same-edge drain/accept.
module tb_alu_pipe;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    alu_pipe_if #(.WIDTH(4), .OPW(4)) bus ();

    alu_pipe #(.WIDTH(4), .OPW(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
        logic       c;
        logic       z;
        logic       az;
        logic       il;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    // {out_valid, alu_out, carry, zero, a_is_zero, illegal}
    function automatic logic [8:0] obs();
        return {bus.out_valid, bus.alu_out, bus.carry, bus.zero, bus.a_is_zero, bus.illegal};
    endfunction

    task automatic drive(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        bus.in_valid = 1'b1;
        bus.opcode   = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    // Called at posedge+1 with out_ready=1; leaves in_valid low at posedge+1.
    task automatic mul_seq(input string nm, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] r, input logic c);
        drive(4'd12, a, b);
        #1 chk({nm, "_rdy"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        drive(4'd2, ~a, ~b);
        chk({nm, "_busy0"}, 32'(bus.in_ready), 32'd0);
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_busy%0d", nm, e), 32'({bus.out_valid, bus.in_ready}), 32'd0);
        end
        @(posedge clk); #1;
        chk({nm, "_res"}, 32'(obs()), 32'({1'b1, r, c, (r == 4'd0), (a == 4'd0), 1'b0}));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        tests = 0;
        fails = 0;
        //       op     a      b      r      c     z     az    il
        vt[0]  = '{4'd2,  4'h1, 4'h3, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{4'd3,  4'h6, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{4'd4,  4'h6, 4'h4, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{4'd5,  4'h1, 4'h4, 4'h4, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{4'd2,  4'hF, 4'h1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{4'd8,  4'h2, 4'h5, 4'hD, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[6]  = '{4'd10, 4'h9, 4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{4'd11, 4'h3, 4'h0, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{4'd9,  4'h5, 4'hA, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{4'd8,  4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[10] = '{4'd0,  4'h7, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{4'd1,  4'h0, 4'h3, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0};
        vt[12] = '{4'd6,  4'h3, 4'h9, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[13] = '{4'd14, 4'h0, 4'h5, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1};
        vt[14] = '{4'd7,  4'h6, 4'h1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[15] = '{4'd15, 4'h9, 4'h0, 4'h9, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[16] = '{4'd13, 4'h2, 4'h7, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.opcode    = '0;
        bus.out_ready = 1'b1;
        #3;
        chk("reset_outputs", 32'(obs()), 32'd0);
        #9 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back single-cycle stream, one result per edge.
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].op, vt[i].a, vt[i].b);
            #1 chk($sformatf("vec%0d_rdy", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk); #1;
            chk($sformatf("vec%0d", i), 32'(obs()),
                32'({1'b1, vt[i].r, vt[i].c, vt[i].z, vt[i].az, vt[i].il}));
        end
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain", 32'(bus.out_valid), 32'd0);

        // Serial multiplies; mid-operation input changes must be ignored.
        mul_seq("mul_3x5", 4'h3, 4'h5, 4'hF, 1'b0);
        mul_seq("mul_6x3", 4'h6, 4'h3, 4'h2, 1'b1);
        @(posedge clk); #1;

        // Hold a result under backpressure, then drain and accept on one edge.
        bus.out_ready = 1'b0;
        drive(4'd2, 4'h2, 4'h3);
        #1 chk("bp_accept_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_first", 32'(obs()), 32'({1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0}));
        drive(4'd8, 4'h7, 4'h1);
        for (int k = 0; k < 10; k++) begin
            #1 chk($sformatf("bp_rdy%0d", k), 32'(bus.in_ready), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("bp_hold%0d", k), 32'(obs()), 32'({1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0}));
        end
        bus.out_ready = 1'b1;
        #1 chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_next", 32'(obs()), 32'({1'b1, 4'h6, 1'b0, 1'b0, 1'b0, 1'b0}));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_drain", 32'(bus.out_valid), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        drive(4'd10, 4'h9, 4'h0);
        @(posedge clk); #1;
        chk("rst_pre_shl", 32'(obs()), 32'({1'b1, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0}));
        drive(4'd12, 4'h3, 4'h5);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk("rst_mul_started", 32'(obs()), 32'({1'b0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk("rst_async_clear", 32'(obs()), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_no_stale%0d", k), 32'({bus.out_valid, bus.in_ready}), 32'b01);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, parametrised successor to the combinational ALU.
- Adds a valid/ready handshake on input and output, registered status flags, and an extended opcode set: SUB, OR, shifts, and a multi-cycle shift-add MUL.
- Sits between the accumulator/operand registers and the writeback path of the CPU datapath.
- Opcodes 0-7 keep the legacy HLT/SKZ/ADD/AND/XOR/LDA/STO/JMP semantics.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).
- OPW, 4, opcode width in bits (fixed at 4; opcode[3]=0 selects the legacy set).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation this cycle.
- in_a  input  WIDTH  operand A (accumulator).
- in_b  input  WIDTH  operand B (memory data).
- opcode  input  OPW  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- alu_out  output  WIDTH  registered result.
- a_is_zero  output  1  captured in_a was 0.
- zero  output  1  alu_out == 0.
- carry  output  1  carry/borrow/shift-out/overflow (see below).
- illegal  output  1  opcode was 13-15.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: out_valid=0, alu_out=0, a_is_zero=0, zero=0, carry=0, illegal=0, FSM=IDLE, multiplier registers cleared.
- Asserting rst_n mid-MUL aborts the operation; no result is produced.
- Transfer: an input transfer occurs on a rising edge with in_valid && in_ready.
- Transfer: an output transfer occurs on a rising edge with out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational, so back-to-back single-cycle ops sustain 1 op/clock while out_ready=1.
- Output hold: while out_valid && !out_ready, alu_out and all flags hold stable.
- FSM IDLE: on accept of a single-cycle op, register the result and flags and set out_valid at that same edge (latency 1). On accept of MUL (12), latch A and B, clear the product, load counter=WIDTH, go to MUL.
- FSM MUL: in_ready=0. Each cycle perform one shift-add step on the 2*WIDTH product and decrement the counter. When the counter reaches 0, go to DONE.
- FSM DONE: wait until !out_valid || out_ready. Then register product[WIDTH-1:0] as alu_out with its flags, set out_valid, return to IDLE.
- MUL latency: out_valid rises at most WIDTH+1 edges after accept (exactly WIDTH+1 if the output is free).
- out_valid clears on an output transfer unless a new result is written at the same edge; a new result wins.
- Opcodes, all results truncated to WIDTH:
  - 0 HLT, 1 SKZ, 6 STO, 7 JMP: alu_out=A.
  - 2 ADD: A+B.
  - 3 AND: A&B.
  - 4 XOR: A^B.
  - 5 LDA: alu_out=B.
  - 8 SUB: A-B, modulo 2^WIDTH.
  - 9 OR: A|B.
  - 10 SHL: A<<1, zero fill.
  - 11 SHR: A>>1, logical, zero fill.
  - 12 MUL: low WIDTH bits of A*B, unsigned.
  - 13-15: alu_out=A, illegal=1.
- carry by opcode:
  - ADD: carry out of the MSB.
  - SUB: borrow, i.e. A<B unsigned.
  - SHL: A MSB.
  - SHR: A LSB.
  - MUL: 1 if the upper WIDTH bits of the product are non-zero.
  - All other opcodes: 0.
- zero is computed from the registered alu_out value.
- a_is_zero is (A==0), using the A captured with the operation.
- illegal is 0 for opcodes 0-12.
- Inputs are sampled only on accept; changes while in_ready=0 are ignored.

Test Plan:
1. WIDTH=4, out_ready=1, stream ADD 0001+0011, AND 0110&0100, XOR 0110^0100, LDA B=0100 on consecutive cycles -> out_valid each cycle one edge after accept, alu_out=0100, 0100, 0010, 0100; carry=0; a_is_zero=0.
2. WIDTH=4: ADD 1111+0001 -> alu_out=0000, carry=1, zero=1. SUB 0010-0101 -> 1101, carry=1. SHL 1001 -> 0010, carry=1. SHR 0011 -> 0001, carry=1.
3. WIDTH=4: MUL 0011*0101 -> in_ready=0 for 5 cycles, then alu_out=1111, carry=0. MUL 0110*0011 -> alu_out=0010, carry=1. Inputs changed mid-MUL are ignored.
4. Backpressure:
   - Hold out_ready=0 after one ADD result -> in_ready=0, alu_out/flags stable for 10 cycles.
   - Raise out_ready -> result consumed and a new op accepted at the same edge.
   - The next result appears one edge later.
5. Edge opcodes: opcode 1110 with A=0000 -> alu_out=0000, illegal=1, a_is_zero=1, zero=1. A following JMP A=0110 -> illegal=0.
6. Reset: assert rst_n=0 asynchronously mid-MUL (cycle 2 of 4) -> out_valid, alu_out and flags go to 0 immediately, without a clock edge. After release, in_ready=1 and no stale MUL result is ever emitted.
